fetch_sequencer: RTL and testbench

//  Instruction-fetch controller that sequences the program counter against instruction memory.

---
 rtl/fetch_if.sv | 39 +++
 rtl/fetch_sequencer.sv | 92 +++++++++
 tb/tb_fetch_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Bundle of the fetch sequencer's control, memory, decode and redirect signals.
// The master modport is the sequencer; the slave modport is PC register, memory, decode and control.
interface fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              start;
  logic              halt;
  logic [ADDR_W-1:0] pc_current;
  logic              pc_step;
  logic              pc_branch_en;
  logic [ADDR_W-1:0] pc_branch_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_data;
  logic              instr_ready;
  logic [ADDR_W-1:0] instr_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              busy;
  logic              fetch_err;

  modport master (
    input  start, halt, pc_current, mem_ack, mem_rdata, instr_ready,
           redirect_valid, redirect_addr,
    output pc_step, pc_branch_en, pc_branch_addr, mem_req, mem_addr,
           instr_valid, instr_data, instr_pc, busy, fetch_err
  );

  modport slave (
    output start, halt, pc_current, mem_ack, mem_rdata, instr_ready,
           redirect_valid, redirect_addr,
    input  pc_step, pc_branch_en, pc_branch_addr, mem_req, mem_addr,
           instr_valid, instr_data, instr_pc, busy, fetch_err
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: one memory read per PC value, hold the word for decode,
// then step or branch the PC. Latches redirect requests and traps memory timeouts.
module fetch_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input logic      clk,
  input logic      rst_n,
  fetch_if.master  bus
);

  localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_STEP,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              redir_pend;
  logic [ADDR_W-1:0] redir_addr;
  logic [DATA_W-1:0] instr_data_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              take_branch;
  logic              fetching;

  assign take_branch = (state_q == S_STEP) && redir_pend;
  assign fetching    = (state_q == S_FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      redir_pend   <= 1'b0;
      redir_addr   <= '0;
      instr_data_q <= '0;
      instr_pc_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      // Counts FETCH cycles spent waiting; zero whenever FETCH is (re)entered.
      cnt_q   <= (fetching && state_d == S_FETCH) ? cnt_q + CNT_W'(1) : '0;

      // A fresh redirect wins over the clear caused by the branch it would replace.
      if (bus.redirect_valid) begin
        redir_pend <= 1'b1;
        redir_addr <= bus.redirect_addr;
      end else if (take_branch) begin
        redir_pend <= 1'b0;
      end

      if (fetching && bus.mem_ack && !redir_pend) begin
        instr_data_q <= bus.mem_rdata;
        instr_pc_q   <= bus.pc_current;
      end
    end
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start && !bus.halt) state_d = redir_pend ? S_STEP : S_FETCH;
      S_FETCH: begin
        if (bus.mem_ack)             state_d = redir_pend ? S_STEP : S_HOLD;
        else if (cnt_q == CNT_LAST)  state_d = S_ERR;
      end
      S_HOLD:  if (bus.instr_ready || redir_pend) state_d = S_STEP;
      S_STEP:  state_d = bus.halt ? S_IDLE : S_FETCH;
      S_ERR:   if (redir_pend) state_d = S_STEP;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_req        = fetching;
  assign bus.mem_addr       = fetching ? bus.pc_current : '0;
  assign bus.instr_valid    = (state_q == S_HOLD);
  assign bus.instr_data     = instr_data_q;
  assign bus.instr_pc       = instr_pc_q;
  assign bus.pc_step        = (state_q == S_STEP);
  assign bus.pc_branch_en   = take_branch;
  assign bus.pc_branch_addr = take_branch ? redir_addr : '0;
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.fetch_err      = (state_q == S_ERR);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic
// compared every cycle against a phase-level reference model of the fetch rules.
module tb_fetch_sequencer;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int TIMEOUT_CYC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_sequencer #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: the controller's phase, FETCH wait count, pending jump and held word.
  typedef enum {M_IDLE, M_FETCH, M_HOLD, M_STEP, M_ERR} phase_t;
  phase_t      m_ph;
  int          m_wait;
  bit          m_pend;
  logic [15:0] m_tgt, m_data, m_ipc;
  logic [15:0] pc;   // the PC register the sequencer steers
  int          m_xfers;

  // Observations taken at the sample point of the latest cycle.
  logic        o_req, o_valid, o_step, o_ben, o_busy, o_err;
  logic [15:0] o_baddr, o_maddr, o_ipc, o_data;
  int          dut_xfers = 0;

  function automatic void model_reset();
    m_ph   = M_IDLE;
    m_wait = 0;
    m_pend = 1'b0;
    m_tgt  = '0;
    m_data = '0;
    m_ipc  = '0;
  endfunction

  function automatic void model_step(bit st, bit hl, bit ack, logic [15:0] rd,
                                     bit rdy, bit rv, logic [15:0] ra);
    bit     branch_taken = (m_ph == M_STEP) && m_pend;
    phase_t nxt = m_ph;
    case (m_ph)
      M_IDLE:  if (st && !hl) nxt = m_pend ? M_STEP : M_FETCH;
      M_FETCH: begin
        m_wait++;
        if (ack) begin
          if (m_pend) nxt = M_STEP;
          else begin
            m_data = rd;
            m_ipc  = pc;
            nxt    = M_HOLD;
          end
        end else if (m_wait == TIMEOUT_CYC) nxt = M_ERR;
      end
      M_HOLD: begin
        if (rdy) m_xfers++;
        if (rdy || m_pend) nxt = M_STEP;
      end
      M_STEP: begin
        pc  = m_pend ? m_tgt : pc + 16'd1;
        nxt = hl ? M_IDLE : M_FETCH;
      end
      M_ERR:   if (m_pend) nxt = M_STEP;
      default: nxt = M_IDLE;
    endcase
    if (nxt == M_FETCH && m_ph != M_FETCH) m_wait = 0;
    if (rv) begin
      m_pend = 1'b1;
      m_tgt  = ra;
    end else if (branch_taken) m_pend = 1'b0;
    m_ph = nxt;
  endfunction

  task automatic check_model();
    bit exp_step = (m_ph == M_STEP);
    bit exp_ben  = exp_step && m_pend;
    check("ctrl", {26'd0, o_req, o_valid, o_step, o_ben, o_busy, o_err},
          {26'd0, m_ph == M_FETCH, m_ph == M_HOLD, exp_step, exp_ben, m_ph != M_IDLE, m_ph == M_ERR});
    check("branch_addr", {16'd0, o_baddr}, {16'd0, exp_ben ? m_tgt : 16'h0});
    check("mem_addr",    {16'd0, o_maddr}, {16'd0, (m_ph == M_FETCH) ? pc : 16'h0});
    check("instr_data",  {16'd0, o_data},  {16'd0, m_data});
    check("instr_pc",    {16'd0, o_ipc},   {16'd0, m_ipc});
  endtask

  // One clock cycle: drive inputs on the falling edge, sample, compare, advance the model.
  task automatic cycle(input bit st, input bit hl, input bit ack, input logic [15:0] rd,
                       input bit rdy, input bit rv, input logic [15:0] ra);
    @(negedge clk);
    bus.start          = st;
    bus.halt           = hl;
    bus.mem_ack        = ack;
    bus.mem_rdata      = rd;
    bus.instr_ready    = rdy;
    bus.redirect_valid = rv;
    bus.redirect_addr  = ra;
    bus.pc_current     = pc;
    #1;
    o_req   = bus.mem_req;
    o_valid = bus.instr_valid;
    o_step  = bus.pc_step;
    o_ben   = bus.pc_branch_en;
    o_busy  = bus.busy;
    o_err   = bus.fetch_err;
    o_baddr = bus.pc_branch_addr;
    o_maddr = bus.mem_addr;
    o_ipc   = bus.instr_pc;
    o_data  = bus.instr_data;
    if (o_valid && rdy) dut_xfers++;
    check_model();
    model_step(st, hl, ack, rd, rdy, rv, ra);
  endtask

  task automatic go_idle();
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 16'h0, 1'b1, m_ph == M_ERR, pc);
      if (!o_busy) done = 1'b1;
    end
    check("reach_idle", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the end of the run");
    $fatal(1);
  end

  initial begin
    int          bens, x0, reqs;
    bit          saw_valid;
    int          step_at[$];
    logic [15:0] ipcs[$];

    bus.start = 0; bus.halt = 0; bus.mem_ack = 0; bus.mem_rdata = '0;
    bus.instr_ready = 0; bus.redirect_valid = 0; bus.redirect_addr = '0;
    pc = 16'h0000; bus.pc_current = pc;
    m_xfers = 0;
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset_ctrl", {26'd0, bus.mem_req, bus.instr_valid, bus.pc_step, bus.pc_branch_en,
                         bus.busy, bus.fetch_err}, 32'd0);
    check("reset_words", {bus.mem_addr | bus.pc_branch_addr, bus.instr_data | bus.instr_pc}, 32'd0);
    rst_n = 1'b1;

    // Sequential flow at best-case rate from PC 0.
    bens = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 16'hA000 + 16'(i), 1'b1, 1'b0, 16'h0);
      if (o_valid) ipcs.push_back(o_ipc);
      if (o_step) begin
        step_at.push_back(i);
        if (o_ben) bens++;
      end
    end
    check("seq_words", ipcs.size(), 3);
    for (int k = 0; k < 3; k++)
      check("seq_instr_pc", {16'd0, (k < ipcs.size()) ? ipcs[k] : 16'hFFFF}, k);
    check("seq_steps", step_at.size(), 3);
    check("seq_step_span", (step_at.size() == 3) ? step_at[2] - step_at[0] : 0, 6);
    check("seq_no_branch", bens, 0);

    // Redirect while FETCH waits: acked word discarded, branch to 0x0040.
    go_idle();
    pc = 16'h0010;
    saw_valid = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0,    1'b0, 1'b1, 16'h0040); saw_valid |= o_valid;
    cycle(1'b1, 1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0);    saw_valid |= o_valid;
    cycle(1'b1, 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 16'h0);    saw_valid |= o_valid;
    check("redir_branch_en",   {31'd0, o_ben}, 32'd1);
    check("redir_branch_addr", {16'd0, o_baddr}, 32'h0040);
    cycle(1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0);
    check("redir_mem_addr", {16'd0, o_maddr}, 32'h0040);
    check("redir_no_valid", {31'd0, saw_valid}, 32'd0);

    // Decode stalls 5 cycles, then accepts together with a redirect to 0x0100.
    x0 = dut_xfers;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      check("stall_valid", {31'd0, o_valid}, 32'd1);
    end
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0100);
    check("stall_word", {o_ipc, o_data}, 32'h0040_1234);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    check("stall_branch", {15'd0, o_ben, o_baddr}, 32'h0001_0100);
    check("stall_xfers", dut_xfers - x0, 1);

    // Memory timeout, ignored late ack and halt, recovery by redirect to 0x0200.
    go_idle();
    pc = 16'h0300;
    reqs = 0;
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < TIMEOUT_CYC; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      reqs += int'(o_req);
    end
    check("tmo_fetch_cycles", reqs, TIMEOUT_CYC);
    cycle(1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0);
    check("tmo_err", {29'd0, o_err, o_req, o_valid}, 32'b100);
    cycle(1'b1, 1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0200);
    check("tmo_err_held", {29'd0, o_err, o_req, o_valid}, 32'b100);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check("tmo_recover", {14'd0, o_err, o_ben, o_baddr}, 32'h0001_0200);
    cycle(1'b1, 1'b0, 1'b1, 16'h0777, 1'b1, 1'b0, 16'h0);
    check("tmo_resume_addr", {16'd0, o_maddr}, 32'h0200);

    // Halt during HOLD: transfer, step, back to IDLE, then resume at PC+1.
    go_idle();
    pc = 16'h0050;
    cycle(1'b1, 1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 16'h0);
    x0 = dut_xfers;
    cycle(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check("halt_step", {30'd0, o_step, o_ben}, 32'b10);
    cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check("halt_idle", {31'd0, o_busy}, 32'd0);
    check("halt_xfers", dut_xfers - x0, 1);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check("halt_resume_addr", {16'd0, o_maddr}, 32'h0051);

    // Asynchronous reset while FETCH is waiting.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {27'd0, bus.mem_req, bus.busy, bus.instr_valid, bus.pc_step, bus.fetch_err},
          32'd0);
    model_reset();
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);

    // Randomized traffic, starting near the top of the address space to cross the wrap.
    go_idle();
    pc = 16'hFFFD;
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
            16'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0, 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
